// File: rtl/br_predictor_gshare.sv
// Gshare direction predictor plus return-address stack producing the next fetch PC.
// GHR is updated speculatively at fetch and repaired from the ROB commit bus on mispredict.
module br_predictor_gshare #(
    parameter int unsigned PHT_LOG2       = 8,
    parameter int unsigned HIST_LEN       = 8,
    parameter int unsigned CNT_W          = 2,
    parameter int unsigned RAS_DEPTH_LOG2 = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                fetch_valid,
    input  logic [31:0]         inst_from_inst_fetcher,
    input  logic [31:0]         pc_from_inst_fetcher,
    output logic [31:0]         next_pc_to_inst_fetcher,
    output logic                pred_taken_to_inst_fetcher,
    output logic [HIST_LEN-1:0] ghr_to_inst_fetcher,
    input  logic                valid_from_rob_bus,
    input  logic [31:0]         pc_from_rob_bus,
    input  logic                is_taken_from_rob_bus,
    input  logic [HIST_LEN-1:0] ghr_from_rob_bus,
    input  logic                mispredict_from_rob_bus
);

    localparam int unsigned PhtSize  = 1 << PHT_LOG2;
    localparam int unsigned RasDepth = 1 << RAS_DEPTH_LOG2;

    localparam logic [CNT_W-1:0] CntInit = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    localparam logic [RAS_DEPTH_LOG2-1:0] PtrOne  = RAS_DEPTH_LOG2'(1);
    localparam logic [RAS_DEPTH_LOG2:0]   RasOne  = (RAS_DEPTH_LOG2 + 1)'(1);
    localparam logic [RAS_DEPTH_LOG2:0]   RasFull = (RAS_DEPTH_LOG2 + 1)'(RasDepth);

    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;

    logic [CNT_W-1:0]          pht_q [PhtSize];
    logic [CNT_W-1:0]          pht_d [PhtSize];
    logic [HIST_LEN-1:0]       ghr_q, ghr_d;
    logic [31:0]               ras_q [RasDepth];
    logic [31:0]               ras_d [RasDepth];
    logic [RAS_DEPTH_LOG2-1:0] ras_ptr_q, ras_ptr_d;
    logic [RAS_DEPTH_LOG2:0]   ras_cnt_q, ras_cnt_d;

    logic [31:0] inst;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic        is_jal, is_jalr, is_branch;
    logic        rd_link, rs1_link;
    logic [31:0] j_imm, b_imm, pc_plus4;

    logic [PHT_LOG2-1:0]       fetch_idx, commit_idx;
    logic [CNT_W-1:0]          fetch_cnt, commit_cnt;
    logic [RAS_DEPTH_LOG2-1:0] ras_top_ptr;
    logic                      ras_push, ras_pop, ras_both;
    logic                      unused_rob_pc;

    assign inst      = inst_from_inst_fetcher;
    assign pc        = pc_from_inst_fetcher;
    assign opcode    = inst[6:0];
    assign rd        = inst[11:7];
    assign rs1       = inst[19:15];
    assign is_jal    = (opcode == OpJal);
    assign is_jalr   = (opcode == OpJalr);
    assign is_branch = (opcode == OpBranch);
    assign rd_link   = (rd == 5'd1) || (rd == 5'd5);
    assign rs1_link  = (rs1 == 5'd1) || (rs1 == 5'd5);
    assign j_imm     = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign b_imm     = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign pc_plus4  = pc + 32'd4;

    assign fetch_idx   = pc[PHT_LOG2+1:2] ^ PHT_LOG2'(ghr_q);
    assign commit_idx  = pc_from_rob_bus[PHT_LOG2+1:2] ^ PHT_LOG2'(ghr_from_rob_bus);
    assign fetch_cnt   = pht_q[fetch_idx];
    assign commit_cnt  = pht_q[commit_idx];
    assign ras_top_ptr = ras_ptr_q - PtrOne;

    assign unused_rob_pc = ^{pc_from_rob_bus[31:PHT_LOG2+2], pc_from_rob_bus[1:0]};

    assign ghr_to_inst_fetcher = ghr_q;

    always_comb begin
        next_pc_to_inst_fetcher    = pc_plus4;
        pred_taken_to_inst_fetcher = 1'b0;
        if (is_jal) begin
            next_pc_to_inst_fetcher    = pc + j_imm;
            pred_taken_to_inst_fetcher = 1'b1;
        end else if (is_jalr) begin
            // Only a pure return (not a co-routine swap) trusts the RAS.
            if (rs1_link && !rd_link && (ras_cnt_q != '0)) begin
                next_pc_to_inst_fetcher = ras_q[ras_top_ptr];
            end
        end else if (is_branch && fetch_cnt[CNT_W-1]) begin
            next_pc_to_inst_fetcher    = pc + b_imm;
            pred_taken_to_inst_fetcher = 1'b1;
        end
    end

    always_comb begin
        ghr_d = ghr_q;
        if (mispredict_from_rob_bus) begin
            ghr_d = HIST_LEN'({ghr_from_rob_bus, is_taken_from_rob_bus});
        end else if (fetch_valid && is_branch) begin
            ghr_d = HIST_LEN'({ghr_q, pred_taken_to_inst_fetcher});
        end
    end

    always_comb begin
        pht_d = pht_q;
        if (valid_from_rob_bus) begin
            if (is_taken_from_rob_bus && (commit_cnt != CntMax)) begin
                pht_d[commit_idx] = commit_cnt + CntOne;
            end else if (!is_taken_from_rob_bus && (commit_cnt != '0)) begin
                pht_d[commit_idx] = commit_cnt - CntOne;
            end
        end
    end

    assign ras_push = fetch_valid && (is_jal || is_jalr) && rd_link;
    assign ras_pop  = fetch_valid && is_jalr && rs1_link;
    assign ras_both = ras_push && ras_pop && (rd != rs1);

    always_comb begin
        ras_d     = ras_q;
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        if (ras_both) begin
            ras_d[ras_top_ptr] = pc_plus4;
        end else if (ras_push) begin
            ras_d[ras_ptr_q] = pc_plus4;
            ras_ptr_d        = ras_ptr_q + PtrOne;
            if (ras_cnt_q != RasFull) begin
                ras_cnt_d = ras_cnt_q + RasOne;
            end
        end else if (ras_pop && (ras_cnt_q != '0)) begin
            ras_ptr_d = ras_ptr_q - PtrOne;
            ras_cnt_d = ras_cnt_q - RasOne;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pht_q     <= '{default: CntInit};
            ghr_q     <= '0;
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else if (rdy) begin
            pht_q     <= pht_d;
            ghr_q     <= ghr_d;
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    // RAS storage carries no reset; the count alone marks valid entries.
    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            ras_q <= ras_d;
        end
    end

endmodule

// File: tb/tb_br_predictor_gshare.sv
// Scoreboard bench for br_predictor_gshare: each fetch pushes its expected next-PC,
// direction and GHR snapshot, which are popped and compared while the fetch is presented.
module tb_br_predictor_gshare;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        fetch_valid;
    logic [31:0] inst_from_inst_fetcher;
    logic [31:0] pc_from_inst_fetcher;
    logic [31:0] next_pc_to_inst_fetcher;
    logic        pred_taken_to_inst_fetcher;
    logic [7:0]  ghr_to_inst_fetcher;
    logic        valid_from_rob_bus;
    logic [31:0] pc_from_rob_bus;
    logic        is_taken_from_rob_bus;
    logic [7:0]  ghr_from_rob_bus;
    logic        mispredict_from_rob_bus;

    typedef struct packed {
        logic [31:0] npc;
        logic        tk;
        logic [7:0]  ghr;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    localparam logic [31:0] Nop = 32'h0000_0013;

    br_predictor_gshare dut (
        .clk                        (clk),
        .rst                        (rst),
        .rdy                        (rdy),
        .fetch_valid                (fetch_valid),
        .inst_from_inst_fetcher     (inst_from_inst_fetcher),
        .pc_from_inst_fetcher       (pc_from_inst_fetcher),
        .next_pc_to_inst_fetcher    (next_pc_to_inst_fetcher),
        .pred_taken_to_inst_fetcher (pred_taken_to_inst_fetcher),
        .ghr_to_inst_fetcher        (ghr_to_inst_fetcher),
        .valid_from_rob_bus         (valid_from_rob_bus),
        .pc_from_rob_bus            (pc_from_rob_bus),
        .is_taken_from_rob_bus      (is_taken_from_rob_bus),
        .ghr_from_rob_bus           (ghr_from_rob_bus),
        .mispredict_from_rob_bus    (mispredict_from_rob_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_b(input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd0, 5'd0, 3'd0, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'd0, rd, 7'b1100111};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        fetch_valid             = 1'b0;
        inst_from_inst_fetcher  = Nop;
        pc_from_inst_fetcher    = 32'h0;
        valid_from_rob_bus      = 1'b0;
        pc_from_rob_bus         = 32'h0;
        is_taken_from_rob_bus   = 1'b0;
        ghr_from_rob_bus        = 8'h0;
        mispredict_from_rob_bus = 1'b0;
    endtask

    task automatic set_commit(input logic [31:0] pc, input logic tk, input logic [7:0] ghr);
        valid_from_rob_bus    = 1'b1;
        pc_from_rob_bus       = pc;
        is_taken_from_rob_bus = tk;
        ghr_from_rob_bus      = ghr;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic commit(input logic [31:0] pc, input logic tk, input logic [7:0] ghr);
        set_commit(pc, tk, ghr);
        tick();
    endtask

    // Any commit/mispredict signals set beforehand share this cycle with the fetch.
    task automatic fetch(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] e_npc, input logic e_tk, input logic [7:0] e_ghr);
        exp_t e;
        fetch_valid            = 1'b1;
        inst_from_inst_fetcher = inst;
        pc_from_inst_fetcher   = pc;
        exp_q.push_back('{npc: e_npc, tk: e_tk, ghr: e_ghr});
        #1;
        e = exp_q.pop_front();
        check({tag, ".npc"}, next_pc_to_inst_fetcher, e.npc);
        check({tag, ".tk"}, {31'd0, pred_taken_to_inst_fetcher}, {31'd0, e.tk});
        check({tag, ".ghr"}, {24'd0, ghr_to_inst_fetcher}, {24'd0, e.ghr});
        tick();
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state and weakly-not-taken branch
        fetch("rst_nop", Nop, 32'h50, 32'h54, 1'b0, 8'h00);
        fetch("br_first", enc_b(13'h020), 32'h100, 32'h104, 1'b0, 8'h00);

        // Train idx 0x40 to strongly taken, check saturation via a later not-taken commit
        commit(32'h100, 1'b1, 8'h00);
        commit(32'h100, 1'b1, 8'h00);
        fetch("br_trained", enc_b(13'h020), 32'h100, 32'h120, 1'b1, 8'h00);
        commit(32'h100, 1'b1, 8'h00);
        commit(32'h100, 1'b0, 8'h00);
        fetch("br_ghr1", enc_b(13'h020), 32'h100, 32'h104, 1'b0, 8'h01);
        fetch("br_sat", enc_b(13'h020), 32'h108, 32'h128, 1'b1, 8'h02);

        // Same-cycle commit to the entry being read: fetch sees the old counter
        set_commit(32'h100, 1'b0, 8'h00);
        fetch("br_rbw", enc_b(13'h020), 32'h114, 32'h134, 1'b1, 8'h05);
        fetch("br_after_wr", enc_b(13'h020), 32'h12C, 32'h130, 1'b0, 8'h0B);

        // Mispredict repair wins over the fetch shift
        mispredict_from_rob_bus = 1'b1;
        is_taken_from_rob_bus   = 1'b1;
        ghr_from_rob_bus        = 8'h5A;
        fetch("br_repair", enc_b(13'h020), 32'h300, 32'h304, 1'b0, 8'h16);
        fetch("ghr_repaired", Nop, 32'h310, 32'h314, 1'b0, 8'hB5);

        // Call / return
        fetch("jal_call", enc_jal(5'd1, 21'h200), 32'h200, 32'h400, 1'b1, 8'hB5);
        fetch("ret_hit", enc_jalr(5'd0, 5'd1), 32'h400, 32'h204, 1'b0, 8'hB5);
        fetch("ret_empty", enc_jalr(5'd0, 5'd1), 32'h400, 32'h404, 1'b0, 8'hB5);

        // Overflow: nine pushes into eight entries
        for (int k = 0; k < 9; k++) begin
            fetch($sformatf("push%0d", k), enc_jal(5'd1, 21'h8), 32'h1000 + 32'(k * 16),
                  32'h1008 + 32'(k * 16), 1'b1, 8'hB5);
        end
        for (int k = 0; k < 8; k++) begin
            fetch($sformatf("pop%0d", k), enc_jalr(5'd0, 5'd1), 32'h2000,
                  32'h1084 - 32'(k * 16), 1'b0, 8'hB5);
        end
        fetch("pop_empty", enc_jalr(5'd0, 5'd1), 32'h2000, 32'h2004, 1'b0, 8'hB5);

        // Co-routine swap replaces the top entry
        fetch("swap_call", enc_jal(5'd1, 21'h100), 32'h600, 32'h700, 1'b1, 8'hB5);
        fetch("swap", enc_jalr(5'd5, 5'd1), 32'h700, 32'h704, 1'b0, 8'hB5);
        fetch("swap_ret", enc_jalr(5'd0, 5'd5), 32'h800, 32'h704, 1'b0, 8'hB5);
        fetch("swap_empty", enc_jalr(5'd0, 5'd1), 32'h900, 32'h904, 1'b0, 8'hB5);

        // rdy low freezes everything
        rdy = 1'b0;
        set_commit(32'h100, 1'b1, 8'h00);
        mispredict_from_rob_bus = 1'b1;
        fetch("stall_jal", enc_jal(5'd1, 21'h10), 32'hA00, 32'hA10, 1'b1, 8'hB5);
        set_commit(32'h100, 1'b1, 8'h00);
        fetch("stall_br", enc_b(13'h020), 32'h3D4, 32'h3D8, 1'b0, 8'hB5);
        rdy = 1'b1;
        fetch("stall_ras", enc_jalr(5'd0, 5'd1), 32'hB00, 32'hB04, 1'b0, 8'hB5);
        fetch("stall_pht", enc_b(13'h020), 32'h3D4, 32'h3D8, 1'b0, 8'hB5);

        // Retrain, then reset mid-stream with competing activity
        commit(32'h100, 1'b1, 8'h00);
        commit(32'h100, 1'b1, 8'h00);
        fetch("pre_rst", enc_b(13'h020), 32'hA8, 32'hC8, 1'b1, 8'h6A);
        rst = 1'b1;
        set_commit(32'h100, 1'b1, 8'h00);
        fetch_valid            = 1'b1;
        inst_from_inst_fetcher = enc_jal(5'd1, 21'h40);
        pc_from_inst_fetcher   = 32'hE00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        fetch("post_rst_br", enc_b(13'h020), 32'h100, 32'h104, 1'b0, 8'h00);
        fetch("post_rst_ras", enc_jalr(5'd0, 5'd1), 32'hC00, 32'hC04, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
